mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width of the shared memory.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter STARVE_MAX, default 4, the maximum number of consecutive cycles fetch may lose arbitration.
REQ-004 CLK  input  1  single clock; all state updates on its rising edge.
REQ-005 RSTn  input  1  reset, asynchronous, active-low.
REQ-006 if_req  input  1  instruction-fetch read request; held with if_addr stable until if_gnt.
REQ-007 if_addr  input  ADDR_W  fetch word address.
REQ-008 if_gnt  output  1  fetch request accepted this cycle.
REQ-009 if_rvalid  output  1  one-cycle pulse; if_rdata valid.
REQ-010 if_rdata  output  DATA_W  fetch read data.
REQ-011 d_req  input  1  data-port request; held with d_we, d_addr and d_wdata stable until d_gnt.
REQ-012 d_we  input  1  1 = write, 0 = read.
REQ-013 d_addr  input  ADDR_W  data word address.
REQ-014 d_wdata  input  DATA_W  write data.
REQ-015 d_gnt  output  1  data request accepted this cycle.
REQ-016 d_rvalid  output  1  one-cycle pulse; d_rdata valid (reads only).
REQ-017 d_rdata  output  DATA_W  data read data.
REQ-018 mem_en, mem_we  output  1 each  shared single-port synchronous RAM enable and write strobe.
REQ-019 mem_addr  output  ADDR_W  RAM address; mem_wdata  output  DATA_W  RAM write data.
REQ-020 mem_rdata  input  DATA_W  RAM read data, valid the cycle after a read access.

Function
REQ-021 The arbiter SHALL issue at most one grant per cycle; the grant is combinational from the current requests and state; mem_en = if_gnt | d_gnt.
REQ-022 When both requests are active, d_req SHALL win, unless starve_cnt == STARVE_MAX, in which case if_req SHALL win.
REQ-023 starve_cnt SHALL increment (saturating at STARVE_MAX) on each cycle with if_req=1 and if_gnt=0, and SHALL clear on if_gnt or on if_req=0.
REQ-024 On grant, mem_addr, mem_we and mem_wdata SHALL carry the winner's address, write flag and write data; with no grant, mem_we=0 and the address and data are don't-care.
REQ-025 Owner FSM states: IDLE, IF_PEND, D_PEND, tracking the outstanding read.
REQ-026 FSM transitions: an if_gnt moves the FSM to IF_PEND; a d_gnt with d_we=0 moves it to D_PEND; a write grant or no grant moves it to IDLE. Transitions are evaluated every cycle, including in the pending states.
REQ-027 In IF_PEND, if_rvalid=1 and if_rdata=mem_rdata; in D_PEND, d_rvalid=1 and d_rdata=mem_rdata; read latency is exactly 1 cycle after the grant.
REQ-028 Back-to-back accesses SHALL be supported: a new grant may occur in the same cycle as the previous read's rvalid, giving full throughput of one access per cycle.
REQ-029 if_rdata and d_rdata SHALL hold their last returned value, held in registers, when the corresponding rvalid=0.
REQ-030 Writes SHALL complete in the grant cycle and never produce an rvalid.
REQ-031 A requester SHALL never receive rvalid without a prior read grant; rvalid SHALL never be asserted to both ports in the same cycle.

Reset
REQ-032 While RSTn=0: FSM=IDLE, starve_cnt=0, if_gnt=d_gnt=0, mem_en=mem_we=0, if_rvalid=d_rvalid=0, if_rdata=d_rdata=0.
REQ-033 If reset is asserted during a pending read, that read SHALL be discarded; no rvalid SHALL appear after reset release.
REQ-034 Arbitration SHALL resume in the first cycle after RSTn rises.

Structure
REQ-035 Package mem_arb_pkg SHALL hold the owner-state enum (IDLE, IF_PEND, D_PEND) and the default ADDR_W, DATA_W and STARVE_MAX constants.
REQ-036 The block is a single module with no sub-modules; the RAM is external.

Verification
REQ-037 Fetch-only read, addr 0x004, RAM word 0x00500093 -> if_gnt in cycle 0; if_rvalid in cycle 1 with if_rdata=0x00500093.
REQ-038 Data write to 0x010 with 0xDEADBEEF, followed by a data read of 0x010 -> d_gnt in two consecutive cycles; d_rvalid in cycle 2 with d_rdata=0xDEADBEEF; no rvalid in cycle 1.
REQ-039 if_req and d_req held continuously, STARVE_MAX=4 -> four d_gnt, then one if_gnt, then the pattern repeats.
REQ-040 Alternating fetch and data reads each cycle -> one grant per cycle; each rvalid goes to the correct port with the matching data, and the two rvalids are never asserted together.
REQ-041 RSTn pulled low in the cycle after a data read grant -> d_rvalid stays 0; all outputs are 0 and the FSM is IDLE after release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the two-port memory arbiter.
// Owner-state encoding tracks which port, if any, has a read in flight.
package mem_arb_pkg;

    localparam int DEF_ADDR_W     = 10;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_STARVE_MAX = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_PEND = 2'd1,
        D_PEND  = 2'd2
    } owner_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and shared RAM port of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one single-port synchronous RAM.
// Data wins contention unless fetch has already lost STARVE_MAX cycles in a row.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic          CLK,
    input  logic          RSTn,
    mem_arbiter_if.slave  bus
);

    localparam int             CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    owner_state_e      state_r;
    owner_state_e      state_next_s;
    logic [CNT_W-1:0]  starve_cnt_r;
    logic              if_gnt_s;
    logic              d_gnt_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] if_rdata_r;
    logic [DATA_W-1:0] d_rdata_r;

    // Grant selection; grants are forced low while reset is held
    always_comb begin
        if_gnt_s = 1'b0;
        d_gnt_s  = 1'b0;
        if (!RSTn) begin
            if_gnt_s = 1'b0;
            d_gnt_s  = 1'b0;
        end else if (bus.if_req && (!bus.d_req || (starve_cnt_r == STARVE_LIM))) begin
            if_gnt_s = 1'b1;
        end else if (bus.d_req) begin
            d_gnt_s = 1'b1;
        end else begin
            if_gnt_s = 1'b0;
            d_gnt_s  = 1'b0;
        end
    end

    // Shared RAM port driven from the winner of this cycle
    always_comb begin
        mem_addr_s    = if_gnt_s ? bus.if_addr : bus.d_addr;
        bus.mem_addr  = mem_addr_s;
        bus.mem_wdata = bus.d_wdata;
        bus.mem_en    = if_gnt_s | d_gnt_s;
        bus.mem_we    = d_gnt_s & bus.d_we;
        bus.if_gnt    = if_gnt_s;
        bus.d_gnt     = d_gnt_s;
    end

    // Consecutive-loss counter for the fetch port, saturating at the limit
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (bus.if_req && !if_gnt_s) begin
            if (starve_cnt_r != STARVE_LIM) begin
                starve_cnt_r <= starve_cnt_r + CNT_W'(1'b1);
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
        end else begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end
    end

    // Owner state register
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Owner next state: re-evaluated every cycle so pending reads can overlap new grants
    always_comb begin
        state_next_s = IDLE;
        if (if_gnt_s) begin
            state_next_s = IF_PEND;
        end else if (d_gnt_s && !bus.d_we) begin
            state_next_s = D_PEND;
        end else begin
            state_next_s = IDLE;
        end
    end

    // Read-return outputs: pass RAM data through while pending, else show held value
    always_comb begin
        bus.if_rvalid = 1'b0;
        bus.d_rvalid  = 1'b0;
        bus.if_rdata  = if_rdata_r;
        bus.d_rdata   = d_rdata_r;
        case (state_r)
            IF_PEND: begin
                bus.if_rvalid = 1'b1;
                bus.if_rdata  = bus.mem_rdata;
            end
            D_PEND: begin
                bus.d_rvalid = 1'b1;
                bus.d_rdata  = bus.mem_rdata;
            end
            IDLE: begin
                bus.if_rvalid = 1'b0;
                bus.d_rvalid  = 1'b0;
            end
            default: begin
                bus.if_rvalid = 1'b0;
                bus.d_rvalid  = 1'b0;
            end
        endcase
    end

    // Capture returned read data so each port keeps its last value between returns
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            if_rdata_r <= {DATA_W{1'b0}};
            d_rdata_r  <= {DATA_W{1'b0}};
        end else begin
            if (state_r == IF_PEND) begin
                if_rdata_r <= bus.mem_rdata;
            end else begin
                if_rdata_r <= if_rdata_r;
            end
            if (state_r == D_PEND) begin
                d_rdata_r <= bus.mem_rdata;
            end else begin
                d_rdata_r <= d_rdata_r;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench: directed scenarios followed by randomized traffic against a
// transaction-level model (priority rule, loss count, shadow memory, expected returns).
module tb_mem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int SMAX = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .CLK  (clk),
        .RSTn (rst_n),
        .bus  (bus)
    );

    function automatic logic [DW-1:0] init_word(input int a);
        if (a == 4) return 32'h0050_0093;
        return (32'(a) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    // Synchronous single-port RAM model driven by the arbiter's memory port
    logic [DW-1:0] ram [1024];
    logic          ram_init = 1'b1;
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 1024; i++) ram[i] <= init_word(i);
        end else if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= ram[bus.mem_addr];
        end
    end

    int total = 0;
    int bad = 0;

    // Reference state
    logic [DW-1:0] shadow [1024];
    int            losses;
    logic          pend_if, pend_d;
    logic [DW-1:0] pend_data, hold_if, hold_d;
    logic          last_if_gnt, last_d_gnt, obs_if_gnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        losses = 0; pend_if = 1'b0; pend_d = 1'b0;
        hold_if = '0; hold_d = '0; pend_data = '0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_if_gnt", bus.if_gnt, 1'b0);
        chk("rst_d_gnt", bus.d_gnt, 1'b0);
        chk("rst_mem_en", bus.mem_en, 1'b0);
        chk("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_if_rvalid", bus.if_rvalid, 1'b0);
        chk("rst_d_rvalid", bus.d_rvalid, 1'b0);
        chk("rst_if_rdata", bus.if_rdata, 32'h0);
        chk("rst_d_rdata", bus.d_rdata, 32'h0);
    endtask

    // One clock cycle: drive at posedge+1, check at posedge+3, advance model, move to next posedge+1
    task automatic step(input logic ir, input logic [AW-1:0] ia, input logic dr,
                        input logic dwe, input logic [AW-1:0] da, input logic [DW-1:0] dwd);
        logic eg_if, eg_d;
        bus.if_req = ir; bus.if_addr = ia;
        bus.d_req = dr; bus.d_we = dwe; bus.d_addr = da; bus.d_wdata = dwd;
        #2;
        eg_if = ir && (!dr || losses == SMAX);
        eg_d  = dr && !eg_if;
        obs_if_gnt = bus.if_gnt;
        chk("if_gnt", bus.if_gnt, eg_if);
        chk("d_gnt", bus.d_gnt, eg_d);
        chk("mem_en", bus.mem_en, eg_if | eg_d);
        chk("mem_we", bus.mem_we, eg_d & dwe);
        if (eg_if) chk("mem_addr_if", bus.mem_addr, ia);
        else if (eg_d) chk("mem_addr_d", bus.mem_addr, da);
        if (eg_d && dwe) chk("mem_wdata", bus.mem_wdata, dwd);
        chk("if_rvalid", bus.if_rvalid, pend_if);
        chk("d_rvalid", bus.d_rvalid, pend_d);
        if (pend_if) hold_if = pend_data;
        if (pend_d)  hold_d  = pend_data;
        chk("if_rdata", bus.if_rdata, hold_if);
        chk("d_rdata", bus.d_rdata, hold_d);
        chk("rvalid_excl", bus.if_rvalid & bus.d_rvalid, 1'b0);
        pend_if = eg_if;
        pend_d  = eg_d && !dwe;
        if (eg_if) pend_data = shadow[ia];
        else if (pend_d) pend_data = shadow[da];
        if (eg_d && dwe) shadow[da] = dwd;
        if (ir && !eg_if) losses = (losses < SMAX) ? losses + 1 : SMAX;
        else losses = 0;
        last_if_gnt = eg_if;
        last_d_gnt  = eg_d;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [9:0] pat;
        logic       ia_act, da_act, dwe_r;
        logic [AW-1:0] ia_r, da_r;
        logic [DW-1:0] dwd_r;

        for (int i = 0; i < 1024; i++) shadow[i] = init_word(i);
        model_reset();
        bus.if_req = 1'b0; bus.if_addr = '0; bus.d_req = 1'b0;
        bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

        // Reset state with both requests asserted
        @(posedge clk); #1;
        ram_init = 1'b0;
        bus.if_req = 1'b1; bus.d_req = 1'b1;
        #2;
        check_reset_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Fetch-only read of 0x004
        step(1'b1, 10'h004, 1'b0, 1'b0, 10'h0, 32'h0);
        step(1'b0, 10'h0, 1'b0, 1'b0, 10'h0, 32'h0);
        chk("fetch_word", hold_if, 32'h0050_0093);

        // Data write then read of 0x010
        step(1'b0, 10'h0, 1'b1, 1'b1, 10'h010, 32'hDEAD_BEEF);
        step(1'b0, 10'h0, 1'b1, 1'b0, 10'h010, 32'h0);
        step(1'b0, 10'h0, 1'b0, 1'b0, 10'h0, 32'h0);
        chk("data_word", bus.d_rdata, 32'hDEAD_BEEF);

        // Both held: four data grants, then one fetch grant, repeating
        pat = '0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 10'h020, 1'b1, 1'b0, 10'h030 + 10'(i), 32'h0);
            pat[i] = obs_if_gnt;
        end
        chk("starve_pattern", pat, 10'b10000_10000);
        step(1'b0, 10'h0, 1'b0, 1'b0, 10'h0, 32'h0);

        // Alternating fetch and data reads
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) step(1'b1, 10'h040 + 10'(i), 1'b0, 1'b0, 10'h0, 32'h0);
            else            step(1'b0, 10'h0, 1'b1, 1'b0, 10'h080 + 10'(i), 32'h0);
        end
        step(1'b0, 10'h0, 1'b0, 1'b0, 10'h0, 32'h0);

        // Reset in the cycle after a data read grant discards the read
        step(1'b0, 10'h0, 1'b1, 1'b0, 10'h010, 32'h0);
        rst_n = 1'b0;
        bus.if_req = 1'b1; bus.d_req = 1'b1;
        #2;
        check_reset_outputs();
        @(posedge clk); #1;
        check_reset_outputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        step(1'b0, 10'h0, 1'b0, 1'b0, 10'h0, 32'h0);
        step(1'b1, 10'h004, 1'b1, 1'b0, 10'h010, 32'h0);
        step(1'b1, 10'h004, 1'b0, 1'b0, 10'h0, 32'h0);

        // Randomized traffic; requesters hold their request until granted
        ia_act = 1'b0; da_act = 1'b0; dwe_r = 1'b0;
        ia_r = '0; da_r = '0; dwd_r = '0;
        for (int n = 0; n < 400; n++) begin
            if (!ia_act) begin
                ia_act = ($urandom_range(0, 99) < 60);
                ia_r   = AW'($urandom_range(0, 63));
            end
            if (!da_act) begin
                da_act = ($urandom_range(0, 99) < 70);
                dwe_r  = ($urandom_range(0, 99) < 40);
                da_r   = AW'($urandom_range(0, 63));
                dwd_r  = $urandom;
            end
            step(ia_act, ia_r, da_act, dwe_r, da_r, dwd_r);
            if (last_if_gnt) ia_act = 1'b0;
            if (last_d_gnt)  da_act = 1'b0;
        end
        step(1'b0, 10'h0, 1'b0, 1'b0, 10'h0, 32'h0);
        step(1'b0, 10'h0, 1'b0, 1'b0, 10'h0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
